reflet_float_div: RTL and testbench

Iterative floating-point divider, the inverse operation of the team's `reflet_float_mult`. It computes `in1 / in2` for IEEE-style operands of width `float_size`, producing one quotient bit per clock. It uses the same `enable`/`ready` handshake and the same simplified number model as the multiplier: no rounding (truncation), no denormals, no NaN, and no over/underflow detection. It sits beside the multiplier in `floating_points_operations/` and is driven by the FPU operation sequencer.

---
 rtl/reflet_float_div_pkg.sv | 38 +++
 rtl/reflet_float_div_div.sv | 101 ++++++++++
 rtl/reflet_float_div.sv | 106 ++++++++++
 tb/tb_reflet_float_div.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/reflet_float_div_pkg.sv
// reflet_float_div_pkg
// Shared definitions for the iterative floating-point divider:
//   - field-width and bias helpers for an IEEE-style float of a given width
//   - state encoding of the restoring-division sequencer
// Port summary: none (package).
package reflet_float_div_pkg;

    // Mantissa (fraction) width for the supported float widths.
    function automatic int mantissa_size(input int float_size);
        case (float_size)
            16:      return 10;
            64:      return 52;
            128:     return 112;
            default: return 23;
        endcase
    endfunction

    // Exponent width: whatever remains after the sign and mantissa.
    function automatic int exponent_size(input int float_size);
        return float_size - 1 - mantissa_size(float_size);
    endfunction

    // Exponent bias: 2^(E-1) - 1.
    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

    // Sequencer states.
    //   S_IDLE   : no operation, ready low
    //   S_DIVIDE : one quotient bit produced per cycle
    //   S_DONE   : quotient held, ready high
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } div_state_t;

endpackage

// File: rtl/reflet_float_div_div.sv
// reflet_float_div_div
// Restoring divider for two normalized significands of `size` bits
// (hidden one included). Produces size+1 quotient bits, MSB first, one per
// clock; quot[size] is the integer bit of the quotient.
//
// Handshake: enable is held high for the whole operation. A start happens on
// the first edge with enable high in S_IDLE; ready rises after the last
// quotient bit is written and stays high while enable stays high. enable low
// returns to S_IDLE on the next edge, discarding the operation.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high reset (wins over enable)
//   enable in   request / hold
//   in1    in   dividend significand
//   in2    in   divisor significand
//   quot   out  quotient register
//   ready  out  quotient valid
//   state  out  current sequencer state (debug visibility)
module reflet_float_div_div
    import reflet_float_div_pkg::*;
#(
    parameter int size = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    output logic [size:0]   quot,
    output logic            ready,
    output div_state_t      state
);

    localparam int            CW       = $clog2(size + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(size + 1);

    div_state_t      r_state;
    logic [size:0]   r_rem;
    logic [size-1:0] r_den;
    logic [CW-1:0]   r_cnt;
    logic [size:0]   r_quot;
    logic            r_ready;

    logic [size:0]   w_den_ext;
    logic [size:0]   w_diff;
    logic            w_ge;

    assign w_den_ext = {1'b0, r_den};
    assign w_ge      = (r_rem >= w_den_ext);
    assign w_diff    = r_rem - w_den_ext;

    // The remainder is always below twice the divisor, so after a subtract
    // its top bit is zero and the left shift cannot lose information.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_ready <= 1'b0;
        end else if (!enable) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rem   <= {1'b0, in1};
                    r_den   <= in2;
                    r_cnt   <= CNT_LOAD;
                    r_quot  <= '0;
                    r_ready <= 1'b0;
                    r_state <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_quot <= {r_quot[size-1:0], w_ge};
                    r_rem  <= w_ge ? {w_diff[size-1:0], 1'b0}
                                   : {r_rem[size-1:0], 1'b0};
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign quot  = r_quot;
    assign ready = r_ready;
    assign state = r_state;

endmodule

// File: rtl/reflet_float_div.sv
// reflet_float_div
// Iterative floating-point divider: div = in1 / in2, one quotient bit per
// clock. Simplified number model: truncation, no denormals, no NaN, no
// over/underflow detection (exponent wraps modulo 2^E).
//
// Handshake: hold enable high for the whole operation; ready rises
// M+3 edges after the start edge and, together with div, stays stable while
// enable stays high. enable low aborts and forces div to 0 combinationally;
// a new operation needs enable low for at least one cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high reset
//   enable in   request / hold
//   in1    in   dividend
//   in2    in   divisor
//   div    out  quotient, 0 while enable is low
//   ready  out  quotient valid
module reflet_float_div
    import reflet_float_div_pkg::*;
#(
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic [float_size-1:0] div,
    output logic                  ready
);

    localparam int           M    = mantissa_size(float_size);
    localparam int           E    = exponent_size(float_size);
    localparam logic [E-1:0] BIAS = E'(exponent_bias(float_size));

    div_state_t      w_state;
    logic [M+1:0]    w_quot;
    logic            w_start;

    logic            r_sign;
    logic [E-1:0]    r_exp1;
    logic [E-1:0]    r_exp2;
    logic            r_zero1;
    logic            r_zero2;

    logic [E-1:0]    w_exp;
    logic [E-1:0]    w_exp_m1;
    logic [float_size-1:0] w_result;

    assign w_start = enable && (w_state == S_IDLE);

    reflet_float_div_div #(
        .size (M + 1)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in1    ({1'b1, in1[M-1:0]}),
        .in2    ({1'b1, in2[M-1:0]}),
        .quot   (w_quot),
        .ready  (ready),
        .state  (w_state)
    );

    // Operand fields are captured on the start edge only, so later changes
    // on in1/in2 cannot disturb a running division. r_zero1 resets high so
    // the assembled result is 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign  <= 1'b0;
            r_exp1  <= '0;
            r_exp2  <= '0;
            r_zero1 <= 1'b1;
            r_zero2 <= 1'b0;
        end else if (w_start) begin
            r_sign  <= in1[float_size-1] ^ in2[float_size-1];
            r_exp1  <= in1[float_size-2:M];
            r_exp2  <= in2[float_size-2:M];
            r_zero1 <= (in1[float_size-2:0] == '0);
            r_zero2 <= (in2[float_size-2:0] == '0);
        end
    end

    assign w_exp    = r_exp1 - r_exp2 + BIAS;
    assign w_exp_m1 = w_exp - 1'b1;

    // Quotient of two significands in [1,2) lies in (0.5,2): either the
    // integer bit is set, or the first fraction bit is and the exponent
    // drops by one.
    always_comb begin
        w_result = '0;
        if (r_zero1) begin
            w_result = '0;
        end else if (r_zero2) begin
            w_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
        end else if (w_quot[M+1]) begin
            w_result = {r_sign, w_exp, w_quot[M:1]};
        end else begin
            w_result = {r_sign, w_exp_m1, w_quot[M-1:0]};
        end
    end

    assign div = enable ? w_result : '0;

endmodule

// File: tb/tb_reflet_float_div.sv
module tb_reflet_float_div;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] div;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;

  localparam int LATENCY = 26;
  localparam int TIMEOUT = 100;

  reflet_float_div #(.float_size(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in1    (in1),
    .in2    (in2),
    .div    (div),
    .ready  (ready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division and wait for ready; checks latency, result, stability
  // and the enable-drop behaviour. With scramble set, the operands are
  // overwritten with random values a few cycles into the division.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit scramble);
    int n;
    in1 = a;
    in2 = b;
    enable = 1'b1;
    n = 0;
    while (1) begin
      tick();
      n++;
      if (scramble && n == 5) begin
        in1 = $urandom;
        in2 = $urandom;
      end
      if (ready) break;
      if (n >= TIMEOUT) break;
    end
    check({tag, "_latency"}, 32'(n), 32'(LATENCY));
    check({tag, "_div"}, div, exp);
    tick();
    tick();
    check({tag, "_hold_div"}, div, exp);
    check({tag, "_hold_ready"}, {31'd0, ready}, 32'd1);
    enable = 1'b0;
    #1;
    check({tag, "_drop_div"}, div, 32'd0);
    tick();
    check({tag, "_drop_ready"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    in1    = '0;
    in2    = '0;
    tick();
    tick();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_div", div, 32'd0);
    reset = 1'b0;
    tick();

    // main function
    run_div("6div2",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    run_div("1div3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    run_div("m15div05", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0);
    run_div("zero_num", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0);
    run_div("zero_den", 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0);

    // abort 10 cycles into 6/2
    in1 = 32'h40C00000;
    in2 = 32'h40000000;
    enable = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    #1;
    check("abort_div", div, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready) check("abort_ready", {31'd0, ready}, 32'd0);
    end
    check("abort_ready_end", {31'd0, ready}, 32'd0);

    // restart with fresh operands, scrambling inputs during the division
    run_div("restart_1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b1);

    // reset mid-divide
    in1 = 32'h40C00000;
    in2 = 32'h40000000;
    enable = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_div", div, 32'd0);
    reset = 1'b0;
    tick();

    // reset in DONE
    enable = 1'b1;
    begin
      int n;
      n = 0;
      while (!ready && n < TIMEOUT) begin
        tick();
        n++;
      end
      check("rst_done_pre_ready", {31'd0, ready}, 32'd1);
    end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    check("rst_done_ready", {31'd0, ready}, 32'd0);
    check("rst_done_div", div, 32'd0);

    // enable held high during reset: start only after reset falls
    enable = 1'b1;
    in1 = 32'h40C00000;
    in2 = 32'h40000000;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) check("rst_hold_ready", {31'd0, ready}, 32'd0);
    end
    check("rst_hold_ready_end", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    run_div("after_rst_6div2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
